// File: rtl/apb_bridge_regfile_if.sv
// APB bus bundle between the bus master and the AES/UART bridge register file.
interface apb_bridge_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NBYTES     = 4
);
  logic                  PSELx;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [NBYTES-1:0]     PSTRB;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    output PSELx, PADDR, PWRITE, PSTRB, PWDATA, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSELx, PADDR, PWRITE, PSTRB, PWDATA, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_bridge_regfile.sv
// APB slave register file with a TX FIFO toward the AES core and an RX FIFO from the UART.
// Only PADDR[3:2] selects a register; TXDATA writes stall while the TX FIFO is full.
module apb_bridge_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NBYTES     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_bridge_regfile_if.slave   bus,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  // ACCESS is the first access-phase cycle after a sampled setup; WAIT holds a stalled access.
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  state_t r_state, w_nextState;

  logic                  r_ctrlEn, r_ctrlIrqEn;
  logic                  r_rxUnderflow, r_rxOverflow;
  logic [DATA_WIDTH-1:0] r_txMem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rxMem [FIFO_DEPTH];
  logic [PTR_W:0]        r_txWrPtr, r_txRdPtr, r_rxWrPtr, r_rxRdPtr;

  logic [1:0]            w_regSel;
  logic                  w_busAccess, w_stall, w_ready, w_wrCommit, w_rdCommit;
  logic                  w_txEmpty, w_txFull, w_rxEmpty, w_rxFull;
  logic                  w_txPush, w_txPop, w_rxPush, w_rxPop, w_statusW1c;
  logic [PTR_W:0]        w_txCount, w_rxCount;
  logic [DATA_WIDTH-1:0] w_txWord, w_status, w_ctrl, w_rxHead;
  logic                  w_unusedAddr;

  assign w_regSel     = bus.PADDR[3:2];
  assign w_unusedAddr = ^{bus.PADDR[ADDR_WIDTH-1:4], bus.PADDR[1:0]};

  assign w_txCount = r_txWrPtr - r_txRdPtr;
  assign w_rxCount = r_rxWrPtr - r_rxRdPtr;
  assign w_txEmpty = (r_txWrPtr == r_txRdPtr);
  assign w_rxEmpty = (r_rxWrPtr == r_rxRdPtr);
  assign w_txFull  = (r_txWrPtr[PTR_W] != r_txRdPtr[PTR_W]) &&
                     (r_txWrPtr[PTR_W-1:0] == r_txRdPtr[PTR_W-1:0]);
  assign w_rxFull  = (r_rxWrPtr[PTR_W] != r_rxRdPtr[PTR_W]) &&
                     (r_rxWrPtr[PTR_W-1:0] == r_rxRdPtr[PTR_W-1:0]);

  assign w_busAccess = (r_state != IDLE) && bus.PSELx && bus.PENABLE;
  assign w_stall     = bus.PWRITE && (w_regSel == REG_TXDATA) && w_txFull;
  assign w_ready     = w_busAccess && !w_stall;
  assign w_wrCommit  = w_ready && bus.PWRITE;
  assign w_rdCommit  = w_ready && !bus.PWRITE;
  assign bus.PREADY  = w_ready;

  assign w_txPush    = w_wrCommit && (w_regSel == REG_TXDATA);
  assign w_txPop     = tx_valid && tx_ready;
  assign w_rxPush    = rx_valid && !w_rxFull;
  assign w_rxPop     = w_rdCommit && (w_regSel == REG_RXDATA) && !w_rxEmpty;
  assign w_statusW1c = w_wrCommit && (w_regSel == REG_STATUS) && bus.PSTRB[2];

  assign tx_data  = r_txMem[r_txRdPtr[PTR_W-1:0]];
  assign tx_valid = r_ctrlEn && !w_txEmpty;
  assign rx_ready = !w_rxFull;
  assign irq      = r_ctrlIrqEn && !w_rxEmpty;
  assign w_rxHead = w_rxEmpty ? '0 : r_rxMem[r_rxRdPtr[PTR_W-1:0]];

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.PSELx && !bus.PENABLE) w_nextState = ACCESS;
      default: begin
        if (!bus.PSELx || w_ready) w_nextState = IDLE;
        else if (!bus.PENABLE)     w_nextState = ACCESS;
        else                       w_nextState = WAIT;
      end
    endcase
  end

  // Bytes without a strobe are pushed as zero rather than merged with anything.
  always_comb begin
    w_txWord = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (bus.PSTRB[b]) w_txWord[8*b +: 8] = bus.PWDATA[8*b +: 8];
    end
  end

  always_comb begin
    w_ctrl        = '0;
    w_ctrl[0]     = r_ctrlEn;
    w_ctrl[1]     = r_ctrlIrqEn;
    w_status      = '0;
    w_status[7:0] = 8'(w_txCount);
    w_status[15:8] = 8'(w_rxCount);
    w_status[16]  = w_txFull;
    w_status[17]  = w_rxEmpty;
    w_status[18]  = r_rxUnderflow;
    w_status[19]  = r_rxOverflow;
  end

  always_comb begin
    bus.PRDATA = '0;
    if (w_busAccess && !bus.PWRITE) begin
      case (w_regSel)
        REG_CTRL:   bus.PRDATA = w_ctrl;
        REG_STATUS: bus.PRDATA = w_status;
        REG_TXDATA: bus.PRDATA = '0;
        default:    bus.PRDATA = w_rxHead;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= IDLE;
      r_ctrlEn      <= 1'b0;
      r_ctrlIrqEn   <= 1'b0;
      r_rxUnderflow <= 1'b0;
      r_rxOverflow  <= 1'b0;
      r_txWrPtr     <= '0;
      r_txRdPtr     <= '0;
      r_rxWrPtr     <= '0;
      r_rxRdPtr     <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_wrCommit && (w_regSel == REG_CTRL) && bus.PSTRB[0]) begin
        r_ctrlEn    <= bus.PWDATA[0];
        r_ctrlIrqEn <= bus.PWDATA[1];
      end
      if (w_rdCommit && (w_regSel == REG_RXDATA) && w_rxEmpty) r_rxUnderflow <= 1'b1;
      else if (w_statusW1c && bus.PWDATA[18])                  r_rxUnderflow <= 1'b0;
      // A new overflow on the same edge as its W1C wins so the event is never lost.
      if (rx_valid && w_rxFull)                    r_rxOverflow <= 1'b1;
      else if (w_statusW1c && bus.PWDATA[19])      r_rxOverflow <= 1'b0;
      if (w_txPush) r_txWrPtr <= r_txWrPtr + PTR_ONE;
      if (w_txPop)  r_txRdPtr <= r_txRdPtr + PTR_ONE;
      if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + PTR_ONE;
      if (w_rxPop)  r_rxRdPtr <= r_rxRdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_txPush) r_txMem[r_txWrPtr[PTR_W-1:0]] <= w_txWord;
    if (w_rxPush) r_rxMem[r_rxWrPtr[PTR_W-1:0]] <= rx_data;
  end
endmodule

// File: tb/tb_apb_bridge_regfile.sv
// Directed and randomized APB/stream stimulus for apb_bridge_regfile, checked against a
// queue-based transaction model of the register map and both FIFOs.
module tb_apb_bridge_regfile;
  localparam int DEPTH = 8;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  apb_bridge_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NBYTES(4)) bus ();

  apb_bridge_regfile #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NBYTES(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] txQ[$];
  logic [31:0] rxQ[$];
  bit          mEn, mIrqEn, mUnf, mOvf;
  bit          randomStream = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] regIdx);
    logic [31:0] v;
    v = '0;
    case (regIdx)
      2'd0: v = {30'b0, mIrqEn, mEn};
      2'd1: begin
        v[7:0]  = 8'(txQ.size());
        v[15:8] = 8'(rxQ.size());
        v[16]   = (txQ.size() == DEPTH);
        v[17]   = (rxQ.size() == 0);
        v[18]   = mUnf;
        v[19]   = mOvf;
      end
      2'd2: v = '0;
      default: v = (rxQ.size() != 0) ? rxQ[0] : 32'h0;
    endcase
    return v;
  endfunction

  // Checks stream outputs with settled inputs, then advances the model across one rising edge.
  task automatic stepEdge(input bit commit, input bit cWrite, input logic [1:0] cReg,
                          input logic [3:0] cStrb, input logic [31:0] cData);
    bit          expValid, txPop, rxFullNow, rxEmptyNow;
    logic [31:0] word;
    expValid = mEn && (txQ.size() != 0);
    checkOutput("tx_valid", {31'b0, tx_valid}, {31'b0, expValid});
    if (expValid) checkOutput("tx_data", tx_data, txQ[0]);
    checkOutput("rx_ready", {31'b0, rx_ready}, {31'b0, rxQ.size() < DEPTH});
    checkOutput("irq", {31'b0, irq}, {31'b0, mIrqEn && (rxQ.size() != 0)});
    txPop      = expValid && tx_ready;
    rxFullNow  = (rxQ.size() == DEPTH);
    rxEmptyNow = (rxQ.size() == 0);
    @(posedge PCLK);
    if (txPop) void'(txQ.pop_front());
    if (commit && cWrite) begin
      case (cReg)
        2'd0: if (cStrb[0]) begin mEn = cData[0]; mIrqEn = cData[1]; end
        2'd1: if (cStrb[2]) begin
          if (cData[18]) mUnf = 0;
          if (cData[19]) mOvf = 0;
        end
        2'd2: begin
          word = '0;
          for (int b = 0; b < 4; b++) if (cStrb[b]) word[8*b +: 8] = cData[8*b +: 8];
          txQ.push_back(word);
        end
        default: ;
      endcase
    end
    if (commit && !cWrite && cReg == 2'd3) begin
      if (rxEmptyNow) mUnf = 1;
      else void'(rxQ.pop_front());
    end
    if (rx_valid) begin
      if (rxFullNow) mOvf = 1;
      else rxQ.push_back(rx_data);
    end
    #1;
    if (randomStream) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = $urandom;
    end
  endtask

  task automatic idleCycle();
    #1;
    stepEdge(0, 0, 2'd0, 4'h0, 32'h0);
  endtask

  // One complete APB transfer; pulseAt raises tx_ready during that stalled cycle (-1 = never).
  task automatic applyStimulus(input bit write, input logic [1:0] regIdx, input logic [3:0] strb,
                               input logic [31:0] wdata, input int pulseAt,
                               output logic [31:0] rdata, output int waits);
    logic [31:0] addr;
    bit          expReady, done, pulsed;
    addr        = $urandom;
    addr[3:2]   = regIdx;
    rdata       = '0;
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = write;
    bus.PADDR   = addr;
    bus.PSTRB   = strb;
    bus.PWDATA  = wdata;
    #1;
    stepEdge(0, write, regIdx, strb, wdata);
    bus.PENABLE = 1'b1;
    waits = 0;
    done  = 0;
    while (!done) begin
      #1;
      expReady = !(write && regIdx == 2'd2 && txQ.size() == DEPTH);
      checkOutput("pready", {31'b0, bus.PREADY}, {31'b0, expReady});
      if (!write) begin
        checkOutput("prdata", bus.PRDATA, modelRead(regIdx));
        rdata = bus.PRDATA;
      end
      pulsed = (pulseAt == waits);
      if (pulsed) tx_ready = 1'b1;
      stepEdge(expReady, write, regIdx, strb, wdata);
      if (pulsed) tx_ready = 1'b0;
      if (expReady) done = 1;
      else begin
        waits++;
        if (waits >= 50) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL apb_timeout waited=%0d cycles limit=50", waits);
          done = 1;
        end
      end
    end
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;
    bus.PSELx = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    bus.PADDR = '0; bus.PSTRB = '0; bus.PWDATA = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    mEn = 0; mIrqEn = 0; mUnf = 0; mOvf = 0;

    #3;
    checkOutput("rst_pready", {31'b0, bus.PREADY}, 32'h0);
    checkOutput("rst_prdata", bus.PRDATA, 32'h0);
    checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge PCLK);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    idleCycle();

    // CTRL write and read-back with zero wait states.
    applyStimulus(1, 2'd0, 4'h1, 32'h0000_0003, -1, rd, w);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t1_ctrl", rd, 32'h0000_0003);
    checkOutput("t1_waits", w, 32'h0);

    // Strobed TXDATA push held while disabled, released once enabled.
    applyStimulus(1, 2'd0, 4'h1, 32'h0, -1, rd, w);
    applyStimulus(1, 2'd2, 4'h5, 32'hDEAD_BEEF, -1, rd, w);
    applyStimulus(0, 2'd1, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t2_status", rd, 32'h0002_0001);
    #1;
    checkOutput("t2_hold_valid", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b1;
    applyStimulus(1, 2'd0, 4'h1, 32'h0000_0001, -1, rd, w);
    #1;
    checkOutput("t2_valid", {31'b0, tx_valid}, 32'h1);
    checkOutput("t2_data", tx_data, 32'h00AD_00EF);
    stepEdge(0, 0, 2'd0, 4'h0, 32'h0);
    #1;
    checkOutput("t2_drained", {31'b0, tx_valid}, 32'h0);
    applyStimulus(0, 2'd1, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t2_status_empty", rd, 32'h0002_0000);

    // TX full stall released by one accepted word.
    tx_ready = 1'b0;
    applyStimulus(1, 2'd0, 4'h1, 32'h0, -1, rd, w);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 2'd2, 4'hF, 32'h1000_0000 + i, -1, rd, w);
    applyStimulus(1, 2'd0, 4'h1, 32'h0000_0001, -1, rd, w);
    applyStimulus(1, 2'd2, 4'hF, 32'hAAAA_5555, 1, rd, w);
    checkOutput("t3_waits", w, 32'h2);
    applyStimulus(0, 2'd1, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t3_status_full", rd, 32'h0003_0008);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) idleCycle();
    tx_ready = 1'b0;

    // RX pushes raise irq; two pops return them in order.
    applyStimulus(1, 2'd0, 4'h1, 32'h0000_0002, -1, rd, w);
    rx_valid = 1'b1;
    rx_data  = 32'h1111_1111;
    idleCycle();
    rx_data  = 32'h2222_2222;
    idleCycle();
    rx_valid = 1'b0;
    #1;
    checkOutput("t4_irq_set", {31'b0, irq}, 32'h1);
    applyStimulus(0, 2'd3, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t4_rx0", rd, 32'h1111_1111);
    applyStimulus(0, 2'd3, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t4_rx1", rd, 32'h2222_2222);
    #1;
    checkOutput("t4_irq_clear", {31'b0, irq}, 32'h0);
    applyStimulus(0, 2'd1, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t4_status", rd, 32'h0002_0000);

    // Underflow flag and its W1C clear.
    applyStimulus(0, 2'd3, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t5_rx_empty_read", rd, 32'h0);
    applyStimulus(0, 2'd1, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t5_underflow", rd, 32'h0006_0000);
    applyStimulus(1, 2'd1, 4'h4, 32'h0004_0000, -1, rd, w);
    applyStimulus(0, 2'd1, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t5_cleared", rd, 32'h0002_0000);

    // Reset during the access phase of a TXDATA write.
    applyStimulus(1, 2'd0, 4'h1, 32'h0000_0003, -1, rd, w);
    rx_valid = 1'b1;
    rx_data  = 32'h3333_3333;
    idleCycle();
    rx_valid    = 1'b0;
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 32'h0000_0008;
    bus.PSTRB   = 4'hF;
    bus.PWDATA  = 32'hCAFE_F00D;
    #1;
    stepEdge(0, 1, 2'd2, 4'hF, 32'hCAFE_F00D);
    bus.PENABLE = 1'b1;
    #1;
    checkOutput("t6_pready_pre", {31'b0, bus.PREADY}, 32'h1);
    checkOutput("t6_irq_pre", {31'b0, irq}, 32'h1);
    PRESETn = 1'b0;
    #1;
    checkOutput("t6_pready", {31'b0, bus.PREADY}, 32'h0);
    checkOutput("t6_prdata", bus.PRDATA, 32'h0);
    checkOutput("t6_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("t6_rx_ready", {31'b0, rx_ready}, 32'h1);
    checkOutput("t6_irq", {31'b0, irq}, 32'h0);
    txQ.delete();
    rxQ.delete();
    mEn = 0; mIrqEn = 0; mUnf = 0; mOvf = 0;
    @(posedge PCLK);
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    idleCycle();
    applyStimulus(0, 2'd1, 4'h0, 32'h0, -1, rd, w);
    checkOutput("t6_status", rd, 32'h0002_0000);

    // Randomized traffic with concurrent stream activity against the model.
    applyStimulus(1, 2'd0, 4'h1, 32'h0000_0003, -1, rd, w);
    randomStream = 1;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0:       begin d[0] = 1'b1; applyStimulus(1, 2'd0, s, d, -1, rd, w); end
        1, 2:    applyStimulus(1, 2'd2, s, d, -1, rd, w);
        3, 4:    applyStimulus(0, 2'd3, 4'h0, 32'h0, -1, rd, w);
        5:       applyStimulus(0, 2'($urandom_range(0, 2)), 4'h0, 32'h0, -1, rd, w);
        6:       applyStimulus(1, 2'd1, s, d, -1, rd, w);
        default: for (int k = 0; k < int'($urandom_range(1, 3)); k++) idleCycle();
      endcase
    end
    randomStream = 0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/apb_bridge_regfile.md
Name: apb_bridge_regfile

Overview:
APB slave register file and FIFO front-end for the AES/UART bridge. It decodes APB transfers from the bus master and holds control and status registers. Writes to TXDATA are pushed into a transmit FIFO that feeds the AES core over a valid/ready stream. Reads of RXDATA pop a receive FIFO filled from the UART side, and an interrupt is raised when receive data is pending.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width and FIFO word width
NBYTES, 4, number of byte strobes (DATA_WIDTH/8)
FIFO_DEPTH, 8, depth of each FIFO (power of two, at least 2)

Ports:
PCLK  in  1  bus clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
PSELx  in  1  slave select
PADDR  in  ADDR_WIDTH  byte address; only bits [3:2] decoded, bits [1:0] ignored
PWRITE  in  1  1 = write, 0 = read
PSTRB  in  NBYTES  write byte enables
PWDATA  in  DATA_WIDTH  write data
PENABLE  in  1  access phase indicator
PRDATA  out  DATA_WIDTH  read data, valid while PREADY=1 in the access phase
PREADY  out  1  transfer completion
tx_data  out  DATA_WIDTH  head word of the TX FIFO, toward AES
tx_valid  out  1  TX FIFO not empty and CTRL.en=1
tx_ready  in  1  AES accepts tx_data on an edge where tx_valid&tx_ready
rx_data  in  DATA_WIDTH  word from the UART side
rx_valid  in  1  push rx_data when rx_ready=1
rx_ready  out  1  RX FIFO not full
irq  out  1  CTRL.irq_en & (RX FIFO not empty)

Behaviour:
- Reset (PRESETn=0, asynchronous): PRDATA=0, PREADY=0, tx_valid=0, rx_ready=1, irq=0. Both FIFOs are emptied, CTRL=0 and the sticky flags are cleared. Reset asserted mid-transfer aborts the transfer with no commit.
- Phase FSM: IDLE -> SETUP on PSELx&~PENABLE. SETUP -> ACCESS on the next edge. ACCESS completes on the edge where PREADY=1, then goes to SETUP if PSELx&~PENABLE, otherwise IDLE. PSELx dropping while in ACCESS returns the FSM to IDLE with no commit.
- PREADY is combinational: PSELx & PENABLE & ~stall.
- stall = 1 only for a TXDATA write while the TX FIFO is full. In every other case the access completes with zero wait states, one cycle after SETUP.
- A commit happens on the completion edge: register writes, FIFO pushes and FIFO pops.
- Register map:
  - 0x0 CTRL (RW): bit0 en, bit1 irq_en, bits[31:2] reserved, read as 0. A write updates each byte whose PSTRB bit is 1.
  - 0x4 STATUS (RO except W1C bits). [7:0] tx_count, [15:8] rx_count, bit16 tx_full, bit17 rx_empty, bit18 rx_underflow (sticky), bit19 rx_overflow (sticky). Writing 1 to bit18 or bit19 with PSTRB[2]=1 clears that bit.
  - 0x8 TXDATA (WO): a write pushes a word made of PWDATA bytes where PSTRB=1 and 0x00 bytes where PSTRB=0. A read returns 0.
  - 0xC RXDATA (RO): a read returns the RX head and pops it. A read while the RX FIFO is empty returns 0, does not pop, and sets rx_underflow. A write is ignored.
- Unmapped addresses do not exist, since only bits [3:2] are decoded.
- PRDATA: during ACCESS of a read it is the combinational mux of the selected register. Outside a read access it is 0.
- TX FIFO:
  - A push and a pop on the same edge leave the count unchanged and keep the data order.
  - The pop condition is tx_valid&tx_ready.
  - When CTRL.en=0, tx_valid=0 and the data is held.
- RX FIFO:
  - rx_valid while full drops the word and sets rx_overflow.
  - A UART push and an APB pop on the same edge are both performed.
  - A push into an empty FIFO is visible to reads and to irq on the next cycle.
- Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit, giving full/empty without ambiguity. Count widths are zero-extended into the 8-bit STATUS fields.

Test Plan:
1. Write CTRL=0x00000003 with PSTRB=0x1, then read CTRL -> PREADY high one cycle after SETUP, read returns 0x00000003.
2. With en=0, write TXDATA 0xDEADBEEF with PSTRB=0x5 -> STATUS[7:0]=1 and tx_valid=0. Set en=1 with tx_ready=1 -> tx_data=0x00AD00EF for one cycle, then tx_count=0.
3. en=0, perform 8 TXDATA writes, then start a 9th -> PREADY held low. Set en=1 and tx_ready=1 for one cycle -> the 9th write completes on the following edge and tx_count=8.
4. Drive rx_valid with 0x11111111 and 0x22222222, and irq_en=1 -> irq=1. Two RXDATA reads return 0x11111111 then 0x22222222, after which irq=0 and rx_empty=1.
5. Read RXDATA while the RX FIFO is empty -> PRDATA=0 and STATUS bit18=1. Write STATUS 0x00040000 with PSTRB=0x4 -> bit18=0.
6. Assert PRESETn=0 during the ACCESS phase of a TXDATA write -> the push does not happen, all outputs return to their reset values, and STATUS reads 0x00020000.
